hc_csr_bank: RTL and testbench

- Parametrised MMIO CSR bank for HardCloud accelerators. It is the successor to the hard-coded per-sample DSM, control and buffer decode.
- Decodes CCI-P MMIO writes on c0 Rx for the DSM base, the control register and NUM_BUFFERS buffer descriptors (64b address, 32b size).
- Answers MMIO reads on c2 Tx and runs the control state machine that gates the accelerator.
- Sits between the CCI-P shim and the accelerator datapath (read/write FSMs).

---
 rtl/hc_pkg.sv | 81 ++++++++
 rtl/hc_ctrl_fsm.sv | 80 ++++++++
 rtl/hc_csr_bank.sv | 137 +++++++++++++
 tb/tb_hc_csr_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// hc_pkg: shared constants, types and helpers for the HardCloud CSR bank.
//   - MMIO byte offsets of the DSM, control, status and buffer registers
//   - HC_CONTROL_* command codes written to the control register
//   - t_hc_address / t_hc_control / t_hc_buffer register types
//   - t_hc_ctrl_state control FSM states
//   - minimal CCI-P c0 Rx (MMIO request) and c2 Tx (MMIO response) channel types
package hc_pkg;

  localparam logic [15:0] HC_STATUS_ADDR   = 16'h108;
  localparam logic [15:0] HC_DSM_ADDR      = 16'h110;
  localparam logic [15:0] HC_CTRL_ADDR     = 16'h118;
  localparam logic [15:0] HC_BUF_BASE_ADDR = 16'h120;
  // Decode window limit in DWORD units (byte 0x400).
  localparam logic [15:0] HC_DECODE_LIMIT  = 16'h100;

  typedef logic [63:0] t_hc_address;
  typedef logic [31:0] t_hc_control;

  localparam t_hc_control HC_CONTROL_ASSERT_RST   = 32'h0;
  localparam t_hc_control HC_CONTROL_DEASSERT_RST = 32'h1;
  localparam t_hc_control HC_CONTROL_START        = 32'h3;
  localparam t_hc_control HC_CONTROL_STOP         = 32'h7;

  typedef struct packed {
    t_hc_address address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3
  } t_hc_ctrl_state;

  localparam logic [1:0] HC_MMIO_LEN_4B = 2'b00;
  localparam logic [1:0] HC_MMIO_LEN_8B = 2'b01;

  typedef struct packed {
    logic [15:0] address;  // DWORD units
    logic [1:0]  length;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioWrValid;
    logic                mmioRdValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  // True when the DWORD address falls inside the 8-byte slot at byte_base.
  function automatic logic hc_qw_hit(input logic [15:0] dw_addr,
                                     input logic [15:0] byte_base);
    return dw_addr[15:1] == 15'(byte_base >> 3);
  endfunction

  // Apply an MMIO write to a 64b register: full 8B, or the addressed 32b half.
  function automatic logic [63:0] hc_merge64(input logic [63:0] old_val,
                                             input logic [63:0] wr_data,
                                             input logic        is8,
                                             input logic        hi);
    logic [63:0] res;
    res = old_val;
    if (is8)     res = wr_data;
    else if (hi) res[63:32] = wr_data[31:0];
    else         res[31:0]  = wr_data[31:0];
    return res;
  endfunction

endpackage

// File: rtl/hc_ctrl_fsm.sv
// hc_ctrl_fsm: accelerator control state machine.
//   clk, rst_n  : clock, synchronous active-low reset
//   ctrl_wr     : a write to the control register is being accepted
//   ctrl_data   : control command (HC_CONTROL_*)
//   done_i      : accelerator job complete pulse
//   state       : current t_hc_ctrl_state
//   acc_rst_n   : registered active-low datapath reset
//   start_o     : one-cycle pulse in the first S_RUN cycle
//   cycle_cnt   : cycles spent in S_RUN (only with HC_CSR_STATUS_EN)
module hc_ctrl_fsm
  import hc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ctrl_wr,
  input  t_hc_control    ctrl_data,
  input  logic           done_i,
  output t_hc_ctrl_state state,
  output logic           acc_rst_n,
  output logic           start_o
`ifdef HC_CSR_STATUS_EN
  ,
  output logic [31:0]    cycle_cnt
`endif
);

  t_hc_ctrl_state state_q, state_d;
  logic           acc_rst_n_q;
  logic           start_q;
  logic           enter_run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      acc_rst_n_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_rst_n_q <= (state_d != S_RESET);
      start_q     <= enter_run;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ctrl_wr && ctrl_data == HC_CONTROL_ASSERT_RST) begin
      state_d = S_RESET;
    end else begin
      case (state_q)
        S_RESET: if (ctrl_wr && ctrl_data == HC_CONTROL_DEASSERT_RST) state_d = S_IDLE;
        S_IDLE:  if (ctrl_wr && ctrl_data == HC_CONTROL_START)        state_d = S_RUN;
        // STOP takes precedence over a coincident done_i.
        S_RUN: begin
          if (ctrl_wr && ctrl_data == HC_CONTROL_STOP) state_d = S_IDLE;
          else if (done_i)                             state_d = S_DONE;
        end
        S_DONE:  if (ctrl_wr && ctrl_data == HC_CONTROL_START)        state_d = S_RUN;
        default: state_d = S_RESET;
      endcase
    end
    enter_run = (state_d == S_RUN) && (state_q != S_RUN);
  end

  assign state     = state_q;
  assign acc_rst_n = acc_rst_n_q;
  assign start_o   = start_q;

`ifdef HC_CSR_STATUS_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                            cnt_q <= '0;
    else if (enter_run)                    cnt_q <= '0;
    else if (state_q == S_RUN && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: rtl/hc_csr_bank.sv
// hc_csr_bank: MMIO CSR bank for HardCloud accelerators.
//   clk, rst_n  : clock, synchronous active-low reset
//   rx_c0       : CCI-P MMIO request channel (read/write, DWORD address)
//   tx_c2       : CCI-P MMIO read response, one cycle after the request
//   done_i      : accelerator job complete pulse
//   acc_rst_n   : active-low datapath reset
//   start_o     : one-cycle start pulse
//   running_o   : high while in S_RUN
//   dsm_base_o  : DSM base address register
//   buffers_o   : NUM_BUFFERS buffer descriptors (64b address, 32b size)
// Optional macro HC_CSR_STATUS_EN adds a read-only status register at
// byte 0x108 holding {state, 29'b0, cycle_cnt}.
module hc_csr_bank
  import hc_pkg::*;
#(
  parameter int unsigned NUM_BUFFERS   = 2,
  parameter logic [15:0] DSM_ADDR      = HC_DSM_ADDR,
  parameter logic [15:0] CTRL_ADDR     = HC_CTRL_ADDR,
  parameter logic [15:0] BUF_BASE_ADDR = HC_BUF_BASE_ADDR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  t_if_ccip_c0_Rx rx_c0,
  output t_if_ccip_c2_Tx tx_c2,
  input  logic           done_i,
  output logic           acc_rst_n,
  output logic           start_o,
  output logic           running_o,
  output logic [63:0]    dsm_base_o,
  output t_hc_buffer     buffers_o [NUM_BUFFERS]
);

  function automatic logic [15:0] buf_base(input int unsigned idx);
    return BUF_BASE_ADDR + 16'(idx * 16);
  endfunction

  logic [15:0]    addr;
  logic           in_win;
  logic           is8;
  logic           hi;
  logic           lo32_ok;
  logic           wr_ok;
  logic           ctrl_wr;
  t_hc_ctrl_state state;
  logic           running;

  t_hc_address    dsm_q;
  t_hc_buffer     buf_q [NUM_BUFFERS];
  logic [63:0]    rd_data;
  logic           rd_valid_q;
  logic [8:0]     rd_tid_q;
  logic [63:0]    rd_data_q;

  assign addr    = rx_c0.hdr.address;
  assign in_win  = addr < HC_DECODE_LIMIT;
  assign is8     = rx_c0.hdr.length == HC_MMIO_LEN_8B;
  assign hi      = addr[0];
  // 32b registers only have a low half; a 4B write to the odd DWORD is dropped.
  assign lo32_ok = is8 || !hi;
  assign wr_ok   = rx_c0.mmioWrValid && in_win;
  assign ctrl_wr = wr_ok && hc_qw_hit(addr, CTRL_ADDR) && lo32_ok;
  assign running = (state == S_RUN);

`ifdef HC_CSR_STATUS_EN
  logic [31:0] cycle_cnt;
`endif

  hc_ctrl_fsm u_ctrl_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl_wr   (ctrl_wr),
    .ctrl_data (rx_c0.data[31:0]),
    .done_i    (done_i),
    .state     (state),
    .acc_rst_n (acc_rst_n),
    .start_o   (start_o)
`ifdef HC_CSR_STATUS_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  // Descriptors and DSM base are frozen while the datapath runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dsm_q <= '0;
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) buf_q[i] <= '0;
    end else if (wr_ok && !running) begin
      if (hc_qw_hit(addr, DSM_ADDR))
        dsm_q <= hc_merge64(dsm_q, rx_c0.data, is8, hi);
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        if (hc_qw_hit(addr, buf_base(i)))
          buf_q[i].address <= hc_merge64(buf_q[i].address, rx_c0.data, is8, hi);
        if (hc_qw_hit(addr, buf_base(i) + 16'd8) && lo32_ok)
          buf_q[i].size <= rx_c0.data[31:0];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (in_win) begin
      if (hc_qw_hit(addr, DSM_ADDR))  rd_data = dsm_q;
      if (hc_qw_hit(addr, CTRL_ADDR)) rd_data = {61'b0, state};
`ifdef HC_CSR_STATUS_EN
      if (hc_qw_hit(addr, HC_STATUS_ADDR)) rd_data = {state, 29'b0, cycle_cnt};
`endif
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        if (hc_qw_hit(addr, buf_base(i)))         rd_data = buf_q[i].address;
        if (hc_qw_hit(addr, buf_base(i) + 16'd8)) rd_data = {32'b0, buf_q[i].size};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_tid_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rx_c0.mmioRdValid;
      if (rx_c0.mmioRdValid) begin
        rd_tid_q  <= rx_c0.hdr.tid;
        rd_data_q <= rd_data;
      end
    end
  end

  assign tx_c2.hdr.tid     = rd_tid_q;
  assign tx_c2.mmioRdValid = rd_valid_q;
  assign tx_c2.data        = rd_data_q;

  assign running_o  = running;
  assign dsm_base_o = dsm_q;
  assign buffers_o  = buf_q;

endmodule

// File: tb/tb_hc_csr_bank.sv
// tb_hc_csr_bank: self-checking bench for hc_csr_bank (NUM_BUFFERS=4).
// Directed vector table, hand-written multi-cycle sequences, then random
// traffic, all checked against a behavioural model of the register map.
module tb_hc_csr_bank;
  import hc_pkg::*;

  localparam int unsigned NB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  t_if_ccip_c0_Rx rx_c0;
  t_if_ccip_c2_Tx tx_c2;
  logic           done_i;
  logic           acc_rst_n;
  logic           start_o;
  logic           running_o;
  logic [63:0]    dsm_base_o;
  t_hc_buffer     buffers_o [NB];

  always #5 clk = ~clk;

  hc_csr_bank #(.NUM_BUFFERS(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_c0      (rx_c0),
    .tx_c2      (tx_c2),
    .done_i     (done_i),
    .acc_rst_n  (acc_rst_n),
    .start_o    (start_o),
    .running_o  (running_o),
    .dsm_base_o (dsm_base_o),
    .buffers_o  (buffers_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: state 0=reset 1=idle 2=run 3=done
  logic [63:0] m_dsm;
  logic [63:0] m_addr [NB];
  logic [31:0] m_size [NB];
  int          m_state;
  logic [31:0] m_cnt;
  logic        m_acc, m_start, m_rdv;
  logic [8:0]  m_tid;
  logic [63:0] m_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [15:0] dw);
    int unsigned b, q;
    b = 32'(dw) * 4;
    q = (b / 8) * 8;
    if (b >= 'h400) return 64'd0;
    if (q == 'h110) return m_dsm;
    if (q == 'h118) return 64'(m_state);
`ifdef HC_CSR_STATUS_EN
    if (q == 'h108) return (64'(m_state) << 61) | 64'(m_cnt);
`endif
    for (int i = 0; i < NB; i++) begin
      if (q == 'h120 + 16 * i) return m_addr[i];
      if (q == 'h128 + 16 * i) return 64'(m_size[i]);
    end
    return 64'd0;
  endfunction

  task automatic m_step(input bit rst, input bit rd, input bit wr, input bit len8,
                        input logic [15:0] dw, input logic [63:0] data,
                        input bit done, input logic [8:0] tid);
    int s, ns;
    int unsigned b, q;
    bit hi, ctrl;
    logic [31:0] v;
    logic [63:0] x;
    if (!rst) begin
      m_dsm = 0; m_state = 0; m_cnt = 0;
      for (int i = 0; i < NB; i++) begin m_addr[i] = 0; m_size[i] = 0; end
      m_acc = 0; m_start = 0; m_rdv = 0; m_tid = 0; m_rdata = 0;
      return;
    end
    s = m_state; ns = s; ctrl = 0; v = 0;
    m_rdv = rd;
    if (rd) begin m_tid = tid; m_rdata = m_read(dw); end
    if (wr && dw < 16'h100) begin
      b = 32'(dw) * 4;
      q = (b / 8) * 8;
      hi = (b % 8) != 0;
      if (s != 2 && q == 'h110) begin
        x = m_dsm;
        if (len8) x = data; else if (hi) x[63:32] = data[31:0]; else x[31:0] = data[31:0];
        m_dsm = x;
      end
      for (int i = 0; i < NB; i++) begin
        if (s != 2 && q == 'h120 + 16 * i) begin
          x = m_addr[i];
          if (len8) x = data; else if (hi) x[63:32] = data[31:0]; else x[31:0] = data[31:0];
          m_addr[i] = x;
        end
        if (s != 2 && q == 'h128 + 16 * i && (len8 || !hi)) m_size[i] = data[31:0];
      end
      if (q == 'h118 && (len8 || !hi)) begin ctrl = 1; v = data[31:0]; end
    end
    if (ctrl && v == 0) ns = 0;
    else if (ctrl && s == 0 && v == 1) ns = 1;
    else if (ctrl && (s == 1 || s == 3) && v == 3) ns = 2;
    else if (ctrl && s == 2 && v == 7) ns = 1;
    if (s == 2 && ns == 2 && done) ns = 3;
    if (ns == 2 && s != 2) m_cnt = 0;
    else if (s == 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_start = (ns == 2 && s != 2);
    m_acc   = (ns != 0);
    m_state = ns;
  endtask

  task automatic step(input bit rst, input bit rd, input bit wr, input bit len8,
                      input logic [15:0] dw, input logic [63:0] data,
                      input bit done, input logic [8:0] tid);
    rst_n                 = rst;
    rx_c0.mmioRdValid     = rd;
    rx_c0.mmioWrValid     = wr;
    rx_c0.hdr.length      = len8 ? HC_MMIO_LEN_8B : HC_MMIO_LEN_4B;
    rx_c0.hdr.address     = dw;
    rx_c0.hdr.tid         = tid;
    rx_c0.data            = data;
    done_i                = done;
    m_step(rst, rd, wr, len8, dw, data, done, tid);
    @(posedge clk);
    #1;
    rx_c0  = '0;
    done_i = 1'b0;
    rst_n  = 1'b1;
    check("acc_rst_n", acc_rst_n, m_acc);
    check("running_o", running_o, m_state == 2);
    check("start_o", start_o, m_start);
    check("dsm_base_o", dsm_base_o, m_dsm);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("buf%0d_addr", i), buffers_o[i].address, m_addr[i]);
      check($sformatf("buf%0d_size", i), buffers_o[i].size, m_size[i]);
    end
    check("rd_valid", tx_c2.mmioRdValid, m_rdv);
    if (m_rdv) begin
      check("rd_tid", tx_c2.hdr.tid, m_tid);
      check("rd_data", tx_c2.data, m_rdata);
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    bit          len8;
    logic [15:0] dw;
    logic [63:0] data;
    bit          done;
    logic [8:0]  tid;
    bit          chk;
    logic [63:0] exp_rd;
    bit          exp_run;
    bit          exp_acc;
  } t_vec;

  t_vec vecs[$];

  initial begin
    logic [63:0] exp_status;
    int unsigned r, k;
    logic [15:0] dw;
    logic [63:0] d;
    bit rd, wr;
    logic [31:0] codes [8];

    rx_c0  = '0;
    done_i = 1'b0;
    rst_n  = 1'b0;
    codes  = '{32'h0, 32'h1, 32'h3, 32'h7, 32'h5, 32'h3, 32'h3, 32'h1};

    // reset state
    step(0, 0, 0, 0, 16'h0, 64'h0, 0, 9'd0);
    step(0, 0, 0, 0, 16'h0, 64'h0, 0, 9'd0);
    check("reset_acc_rst_n", acc_rst_n, 1'b0);
    check("reset_rd_valid", tx_c2.mmioRdValid, 1'b0);

    //                rd wr l8 dw      data                      dn tid  chk exp_rd                  run acc
    vecs.push_back('{0, 1, 1, 16'h44, 64'h1234_5678_9ABC_DEF0, 0, 9'd0,  0, 64'h0,                  0, 0});
    vecs.push_back('{1, 0, 0, 16'h44, 64'h0,                   0, 9'd5,  1, 64'h1234_5678_9ABC_DEF0, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h55, 64'hAAAA_0000,           0, 9'd0,  0, 64'h0,                  0, 0});
    vecs.push_back('{0, 1, 0, 16'h56, 64'h40,                  0, 9'd0,  0, 64'h0,                  0, 0});
    vecs.push_back('{1, 0, 0, 16'h54, 64'h0,                   0, 9'd1,  1, 64'hAAAA_0000_0000_0000, 0, 0});
    vecs.push_back('{1, 0, 0, 16'h56, 64'h0,                   0, 9'd2,  1, 64'h40,                 0, 0});
    vecs.push_back('{0, 1, 1, 16'h46, 64'hFFFF_FFFF_0000_0001, 0, 9'd0,  0, 64'h0,                  0, 1});
    vecs.push_back('{1, 0, 0, 16'h46, 64'h0,                   0, 9'd3,  1, 64'h1,                  0, 1});
    vecs.push_back('{0, 1, 0, 16'h46, 64'h5,                   0, 9'd0,  0, 64'h0,                  0, 1});
    vecs.push_back('{0, 1, 0, 16'h46, 64'h3,                   0, 9'd0,  0, 64'h0,                  1, 1});
    vecs.push_back('{0, 0, 0, 16'h0,  64'h0,                   0, 9'd0,  0, 64'h0,                  1, 1});
    vecs.push_back('{0, 1, 1, 16'h48, 64'hDEAD,                0, 9'd0,  0, 64'h0,                  1, 1});
    vecs.push_back('{1, 0, 0, 16'h48, 64'h0,                   0, 9'd7,  1, 64'h0,                  1, 1});
    vecs.push_back('{0, 1, 0, 16'h46, 64'h7,                   1, 9'd0,  0, 64'h0,                  0, 1});
    vecs.push_back('{1, 0, 0, 16'h46, 64'h0,                   0, 9'd8,  1, 64'h1,                  0, 1});
    vecs.push_back('{0, 1, 1, 16'h144, 64'h55,                 0, 9'd0,  0, 64'h0,                  0, 1});
    vecs.push_back('{1, 0, 0, 16'h44, 64'h0,                   0, 9'd9,  1, 64'h1234_5678_9ABC_DEF0, 0, 1});
    vecs.push_back('{1, 0, 0, 16'h100, 64'h0,                  0, 9'd10, 1, 64'h0,                  0, 1});
    vecs.push_back('{0, 1, 1, 16'h4A, 64'hFFFF_FFFF_0000_0010, 0, 9'd0,  0, 64'h0,                  0, 1});
    vecs.push_back('{0, 1, 0, 16'h4B, 64'h99,                  0, 9'd0,  0, 64'h0,                  0, 1});
    vecs.push_back('{1, 0, 0, 16'h4A, 64'h0,                   0, 9'd11, 1, 64'h10,                 0, 1});
    vecs.push_back('{0, 1, 1, 16'h60, 64'h77,                  0, 9'd0,  0, 64'h0,                  0, 1});
    vecs.push_back('{1, 0, 0, 16'h60, 64'h0,                   0, 9'd12, 1, 64'h0,                  0, 1});
    vecs.push_back('{0, 1, 1, 16'h42, 64'h1234,                0, 9'd0,  0, 64'h0,                  0, 1});
    vecs.push_back('{0, 1, 0, 16'h47, 64'h3,                   0, 9'd0,  0, 64'h0,                  0, 1});
    vecs.push_back('{1, 0, 0, 16'h46, 64'h0,                   0, 9'd13, 1, 64'h1,                  0, 1});

    foreach (vecs[i]) begin
      step(1, vecs[i].rd, vecs[i].wr, vecs[i].len8, vecs[i].dw, vecs[i].data,
           vecs[i].done, vecs[i].tid);
      check($sformatf("vec%0d_running", i), running_o, vecs[i].exp_run);
      check($sformatf("vec%0d_acc_rst_n", i), acc_rst_n, vecs[i].exp_acc);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_rd_valid", i), tx_c2.mmioRdValid, 1'b1);
        check($sformatf("vec%0d_rd_tid", i), tx_c2.hdr.tid, vecs[i].tid);
        check($sformatf("vec%0d_rd_data", i), tx_c2.data, vecs[i].exp_rd);
      end
    end

    // Run for 100 cycles, finish with done_i, read the status register.
    step(1, 0, 1, 0, 16'h46, 64'h3, 0, 9'd0);
    check("seq_start_pulse", start_o, 1'b1);
    for (int i = 0; i < 99; i++) step(1, 0, 0, 0, 16'h0, 64'h0, 0, 9'd0);
    check("seq_start_once", start_o, 1'b0);
    step(1, 0, 0, 0, 16'h0, 64'h0, 1, 9'd0);
    check("seq_done_running", running_o, 1'b0);
    step(1, 1, 0, 1, 16'h42, 64'h0, 0, 9'd20);
`ifdef HC_CSR_STATUS_EN
    exp_status = 64'h6000_0000_0000_0064;
`else
    exp_status = 64'h0;
`endif
    check("seq_status", tx_c2.data, exp_status);
    step(1, 1, 0, 0, 16'h46, 64'h0, 0, 9'd21);
    check("seq_state_done", tx_c2.data, 64'h3);
    step(1, 0, 1, 0, 16'h46, 64'h3, 0, 9'd0);
    check("seq_rerun", running_o, 1'b1);

    // Reset mid-run with a read presented in the same cycle.
    step(0, 1, 0, 1, 16'h44, 64'h0, 0, 9'd22);
    check("rst_rd_valid", tx_c2.mmioRdValid, 1'b0);
    check("rst_running", running_o, 1'b0);
    check("rst_dsm", dsm_base_o, 64'h0);
    check("rst_buf3_size", buffers_o[3].size, 32'h0);
    step(1, 1, 0, 0, 16'h46, 64'h0, 0, 9'd23);
    check("rst_state", tx_c2.data, 64'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      k  = $urandom_range(0, 9);
      if (k <= 1)      dw = 16'h46;
      else if (k == 2) dw = 16'h44 + 16'($urandom_range(0, 1));
      else if (k <= 6) dw = 16'h48 + 16'($urandom_range(0, 15));
      else if (k == 7) dw = 16'h42;
      else if (k == 8) dw = 16'($urandom_range(0, 'hFF));
      else             dw = 16'($urandom_range('h100, 'hFFFF));
      if (dw == 16'h46) begin
        d = {32'($urandom), codes[$urandom_range(0, 7)]};
        if ($urandom_range(0, 7) == 0) d[31:0] = $urandom;
      end else begin
        d = {32'($urandom), 32'($urandom)};
      end
      rd = (r < 40);
      wr = (r >= 40 && r < 85);
      step(r != 99, rd, wr, 1'($urandom_range(0, 1)), dw, d,
           $urandom_range(0, 7) == 0, 9'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
